// File: rtl/arb_client.sv
// arb_client: requester-side agent for the 4-channel Req/Gnt arbiter.
// Each channel queues job tokens in a saturating counter, requests while work
// is pending, holds a grant for BURST cycles per job, then drops Req for one
// cycle (REL) so the arbiter can rotate. Sticky flags report counter overflow,
// starvation (watchdog in REQ) and grants received without a request.
//
// Optional feature macro: ARB_CLIENT_MUTEX_CHK_EN. When defined, MutexErr
// latches whenever two or more grants are seen at the same posedge. When not
// defined, MutexErr is tied low and no checker logic exists.
//
// Handshake: ReqN is a decode of the registered channel state (high in REQ
// and HOLD). GntN is sampled at posedge. A grant is legal only while ReqN is
// high; the holder must keep seeing GntN on every edge of its burst, or the
// burst is abandoned, the job is kept and the channel re-requests.
//
// dbg_state packs the four 2-bit channel states {ch3,ch2,ch1,ch0}
// (0 IDLE, 1 REQ, 2 HOLD, 3 REL).

module arb_client #(
    parameter int CNT_W = 3,
    parameter int BURST = 4,
    parameter int WDOG  = 64
) (
    input  logic               Clk,
    input  logic               Resetl,
    input  logic               Job0,
    input  logic               Job1,
    input  logic               Job2,
    input  logic               Job3,
    input  logic               Gnt0,
    input  logic               Gnt1,
    input  logic               Gnt2,
    input  logic               Gnt3,
    output logic               Req0,
    output logic               Req1,
    output logic               Req2,
    output logic               Req3,
    output logic               Busy0,
    output logic               Busy1,
    output logic               Busy2,
    output logic               Busy3,
    output logic               Done0,
    output logic               Done1,
    output logic               Done2,
    output logic               Done3,
    output logic [4*CNT_W-1:0] Pend,
    output logic [3:0]         Ovf,
    output logic [3:0]         Starve,
    output logic [3:0]         ProtErr,
    output logic               MutexErr,
    output logic [7:0]         dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_REL  = 2'd3
    } state_t;

    // Watchdog counter only has to reach WDOG, where it saturates.
    localparam int              WD_W       = $clog2(WDOG + 1);
    localparam logic [WD_W-1:0] WDOG_MAX   = WD_W'(WDOG);
    localparam logic [7:0]      BURST_INIT = 8'(BURST - 1);
    localparam logic [CNT_W-1:0] PEND_MAX  = '1;

    logic [3:0] job;
    logic [3:0] gnt;
    logic [3:0] req;
    logic [3:0] busy;
    logic [3:0] done;

    assign job = {Job3, Job2, Job1, Job0};
    assign gnt = {Gnt3, Gnt2, Gnt1, Gnt0};

    assign Req0  = req[0];
    assign Req1  = req[1];
    assign Req2  = req[2];
    assign Req3  = req[3];
    assign Busy0 = busy[0];
    assign Busy1 = busy[1];
    assign Busy2 = busy[2];
    assign Busy3 = busy[3];
    assign Done0 = done[0];
    assign Done1 = done[1];
    assign Done2 = done[2];
    assign Done3 = done[3];

    for (genvar c = 0; c < 4; c++) begin : g_ch
        state_t           state_q;
        state_t           state_d;
        logic [CNT_W-1:0] pend_q;
        logic [CNT_W-1:0] pend_d;
        logic [7:0]       burst_q;
        logic [7:0]       burst_d;
        logic [WD_W-1:0]  wd_q;
        logic [WD_W-1:0]  wd_d;
        logic             ovf_q;
        logic             ovf_d;
        logic             starve_q;
        logic             starve_d;
        logic             prot_q;
        logic             prot_d;
        logic             in_rel;
        logic             req_c;
        logic             busy_c;
        logic             done_c;

        assign in_rel = (state_q == ST_REL);

        // State register plus the per-channel counters and sticky flags.
        always_ff @(posedge Clk) begin
            if (!Resetl) begin
                state_q  <= ST_IDLE;
                pend_q   <= '0;
                burst_q  <= '0;
                wd_q     <= '0;
                ovf_q    <= 1'b0;
                starve_q <= 1'b0;
                prot_q   <= 1'b0;
            end else begin
                state_q  <= state_d;
                pend_q   <= pend_d;
                burst_q  <= burst_d;
                wd_q     <= wd_d;
                ovf_q    <= ovf_d;
                starve_q <= starve_d;
                prot_q   <= prot_d;
            end
        end

        // Pending-job counter: a job and a REL completion cancel out; a job
        // arriving at saturation is dropped and flagged.
        always_comb begin
            pend_d = pend_q;
            ovf_d  = ovf_q;
            if (job[c] && !in_rel) begin
                if (pend_q == PEND_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    pend_d = pend_q + 1'b1;
                end
            end else if (!job[c] && in_rel && (pend_q != '0)) begin
                pend_d = pend_q - 1'b1;
            end
        end

        // Next-state logic for the channel FSM.
        always_comb begin
            state_d = state_q;
            case (state_q)
                ST_IDLE: begin
                    if (pend_q != '0) begin
                        state_d = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (gnt[c]) begin
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Burst end wins over a missing grant: all BURST cycles
                    // were already covered by grants at that point.
                    if (burst_q == 8'd0) begin
                        state_d = ST_REL;
                    end else if (!gnt[c]) begin
                        state_d = ST_REQ;
                    end
                end
                ST_REL: begin
                    // Post-update count decides whether more work remains.
                    state_d = (pend_d != '0) ? ST_REQ : ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Burst counter, starvation watchdog and protocol checker.
        always_comb begin
            burst_d  = burst_q;
            wd_d     = wd_q;
            starve_d = starve_q;
            prot_d   = prot_q | (gnt[c] && (state_q == ST_IDLE || in_rel));
            case (state_q)
                ST_REQ: begin
                    if (gnt[c]) begin
                        burst_d = BURST_INIT;
                        wd_d    = '0;
                    end else if (wd_q != WDOG_MAX) begin
                        wd_d = wd_q + 1'b1;
                        if (wd_d == WDOG_MAX) begin
                            starve_d = 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    wd_d = '0;
                    if (burst_q != 8'd0) begin
                        burst_d = burst_q - 8'd1;
                    end
                end
                default: begin
                    wd_d = '0;
                end
            endcase
        end

        // Moore outputs decoded from the registered state.
        always_comb begin
            req_c  = 1'b0;
            busy_c = 1'b0;
            done_c = 1'b0;
            case (state_q)
                ST_REQ:  req_c = 1'b1;
                ST_HOLD: begin
                    req_c  = 1'b1;
                    busy_c = 1'b1;
                end
                ST_REL:  done_c = 1'b1;
                default: ;
            endcase
        end

        assign req[c]                   = req_c;
        assign busy[c]                  = busy_c;
        assign done[c]                  = done_c;
        assign Pend[c*CNT_W +: CNT_W]   = pend_q;
        assign Ovf[c]                   = ovf_q;
        assign Starve[c]                = starve_q;
        assign ProtErr[c]               = prot_q;
        assign dbg_state[2*c +: 2]      = state_q;
    end

`ifdef ARB_CLIENT_MUTEX_CHK_EN
    logic mutex_q;
    logic multi_gnt;

    // Two or more grants: clearing the lowest set bit still leaves one set.
    assign multi_gnt = ((gnt & (gnt - 4'd1)) != 4'd0);

    // Sticky multi-grant flag.
    always_ff @(posedge Clk) begin
        if (!Resetl) begin
            mutex_q <= 1'b0;
        end else if (multi_gnt) begin
            mutex_q <= 1'b1;
        end
    end

    assign MutexErr = mutex_q;
`else
    assign MutexErr = 1'b0;
`endif

endmodule

// File: doc/arb_client.md
Name: arb_client

Overview:
- Requester-side agent for the 4-channel Req/Gnt arbiter (arb); one instance drives all four request lines and consumes the four grants.
- Per channel: queues job tokens, raises Req while work is pending, holds the granted resource for a fixed burst, then releases.
- Flags protocol violations and starvation.
- Replaces randomized bench stimulus in system-level use.

Parameters:
- CNT_W, 3, width of per-channel pending-job counter; max pending = 2^CNT_W-1.
- BURST, 4, cycles a channel holds a grant per job (1..255).
- WDOG, 64, cycles in REQ without a grant before the Starve flag sets (1..65535).

Ports:
- Clk  input  1  single clock; all logic on posedge.
- Resetl  input  1  reset, synchronous, active-low.
- Job0..Job3  input  1 each  one-cycle pulse enqueues one job on that channel.
- Gnt0..Gnt3  input  1 each  grants from the arbiter.
- Req0..Req3  output  1 each  registered requests to the arbiter.
- Busy0..Busy3  output  1 each  channel is in HOLD.
- Done0..Done3  output  1 each  one-cycle pulse when a job completes.
- Pend  output  4*CNT_W  pending counts packed {ch3,ch2,ch1,ch0}.
- Ovf  output  4  sticky: job pulse arrived with counter saturated.
- Starve  output  4  sticky: WDOG expired in REQ.
- ProtErr  output  4  sticky: Gnt high while own Req low.
- MutexErr  output  1  sticky: more than one grant at once (optional feature).

Behaviour:
- Reset (Resetl=0 at posedge): all FSMs to IDLE; all outputs, counters and sticky flags to 0. Reset mid-HOLD discards the in-flight job; no Done pulse.
- Per-channel FSM, Gnt sampled at posedge:
  - IDLE: Req=0. Go to REQ when Pend>0.
  - REQ: Req=1, watchdog counts. Gnt=1 -> HOLD with burst counter=BURST-1, watchdog cleared.
  - HOLD: Req=1, Busy=1, burst counter decrements. At 0 -> REL.
  - HOLD, Gnt=0 before burst end (grant stolen): back to REQ; job kept; burst restarts on next grant.
  - REL: Req=0 for exactly one cycle so the arbiter can rotate. Done=1 this cycle; Pend decrements. Next state: REQ if post-decrement Pend>0, else IDLE.
- Latency: Job pulse at edge t -> Pend updates at t -> Req=1 after edge t+1 (registered, from IDLE). Gnt seen at edge g -> Busy from g for BURST cycles -> Done one cycle later.
- Counter rules:
  - Job and REL decrement in the same cycle -> Pend unchanged.
  - Job with Pend at max (and no decrement that cycle) -> Pend holds at max, Ovf bit sets; the job is dropped.
  - Pend never underflows; REL is reachable only with Pend>=1.
- Watchdog: counts only in REQ. Reaching WDOG sets the Starve bit; counter saturates there; the channel keeps requesting. Starve clears only on reset.
- ProtErr: Gnt=1 at a posedge where the registered Req=0 (IDLE or REL). Gnt in REL is an error; the arbiter must drop Gnt within one cycle of Req falling. The grant is otherwise ignored.
- Channels are fully independent; no cross-channel priority inside this block.

Optional Feature:
- Macro ARB_CLIENT_MUTEX_CHK_EN.
- Defined: MutexErr sets when two or more of Gnt0..Gnt3 are 1 at the same posedge; sticky until reset.
- Undefined: MutexErr tied 0 and no checker logic is generated; all other behaviour identical.

Test Plan:
- Reset then single job: Job0 pulse, model arbiter grants the cycle after Req0 rises -> Req0=1, Busy0 high 4 cycles, Done0 one cycle with Req0=0, Pend ch0 0->... ends 0, FSM IDLE.
- Back-to-back queue: three Job1 pulses, Gnt1 tied to Req1 -> Pend ch1=3, three HOLD bursts each separated by one Req1=0 cycle, three Done1 pulses, Pend returns to 0.
- Saturation and simultaneous events: 8 Job2 pulses with Gnt2=0 -> Pend ch2=7, Ovf[2]=1. Job2 in the same cycle as a Done2 -> Pend unchanged.
- Stolen grant: Gnt3 drops after 2 HOLD cycles -> back to REQ, no Done3, Pend unchanged. On regrant, a full 4-cycle burst precedes Done3.
- Starvation and protocol: WDOG=8, Job0 with Gnt0=0 -> Starve[0]=1 after 8 REQ cycles while Req0 stays 1. Gnt1 pulse with Req1=0 -> ProtErr[1]=1.
- Mutex (macro defined) and reset mid-burst: Gnt0=Gnt2=1 in one cycle -> MutexErr=1. Resetl=0 during HOLD -> all outputs 0 next cycle, no Done pulse.
